// File: rtl/im_stream_loader.sv
// rtl/im_stream_loader.sv - framed byte stream to instruction-memory writer
// Holds the CPU in reset until a SYNC/N/words/CHK frame is written and its checksum matches.
module im_stream_loader #(
    parameter int          INSTR_W   = 15,
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    words_loaded
);

    // Compare width wide enough for both the 8-bit count and 2**ADDR_W.
    localparam int            CW      = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
    localparam logic [CW-1:0] DEPTH_C = {{(CW-1){1'b0}}, 1'b1} << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA_LO,
        S_DATA_HI,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q;
    logic [7:0]         n_q;
    logic [7:0]         chk_q;
    logic [7:0]         lo_q;
    logic               in_ready_q;
    logic               im_we_q;
    logic [ADDR_W-1:0]  im_addr_q;
    logic [INSTR_W-1:0] im_wdata_q;
    logic               cpu_hold_q;
    logic               done_q;
    logic               error_q;
    logic [ADDR_W:0]    words_loaded_q;

    logic [ADDR_W:0]    wl_inc_d;
    logic               last_word_d;
    logic               too_big_d;

    assign wl_inc_d    = words_loaded_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word_d = (CW'(wl_inc_d) == CW'(n_q));
    assign too_big_d   = (CW'(in_data) > DEPTH_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            n_q            <= 8'd0;
            chk_q          <= 8'd0;
            lo_q           <= 8'd0;
            in_ready_q     <= 1'b1;
            im_we_q        <= 1'b0;
            im_addr_q      <= '0;
            im_wdata_q     <= '0;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            im_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && (in_data == SYNC_BYTE)) begin
                        state_q <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (in_valid) begin
                        n_q            <= in_data;
                        chk_q          <= in_data;
                        words_loaded_q <= '0;
                        if (in_data == 8'd0) begin
                            state_q <= S_CHECK;
                        end else if (too_big_d) begin
                            state_q    <= S_ERROR;
                            error_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= S_DATA_LO;
                        end
                    end
                end
                S_DATA_LO: begin
                    if (in_valid) begin
                        lo_q    <= in_data;
                        chk_q   <= chk_q ^ in_data;
                        state_q <= S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    // The write issues on this edge, so it is visible one cycle after accept.
                    if (in_valid) begin
                        chk_q          <= chk_q ^ in_data;
                        im_we_q        <= 1'b1;
                        im_addr_q      <= words_loaded_q[ADDR_W-1:0];
                        im_wdata_q     <= INSTR_W'({in_data, lo_q});
                        words_loaded_q <= wl_inc_d;
                        state_q        <= last_word_d ? S_CHECK : S_DATA_LO;
                    end
                end
                S_CHECK: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (in_data == chk_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q    <= S_IDLE;
                        done_q     <= 1'b0;
                        cpu_hold_q <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                S_ERROR: begin
                    if (start) begin
                        state_q    <= S_IDLE;
                        error_q    <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_im_stream_loader.sv
// tb/tb_im_stream_loader.sv - scoreboard bench for im_stream_loader (ADDR_W=8 and ADDR_W=4 instances)
module tb_im_stream_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid_a;
    logic        in_valid_b;

    logic        in_ready_a, im_we_a, cpu_hold_a, done_a, error_a;
    logic [7:0]  im_addr_a;
    logic [14:0] im_wdata_a;
    logic [8:0]  words_loaded_a;

    logic        in_ready_b, im_we_b, cpu_hold_b, done_b, error_b;
    logic [3:0]  im_addr_b;
    logic [14:0] im_wdata_b;
    logic [4:0]  words_loaded_b;

    im_stream_loader #(.INSTR_W(15), .ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .im_we(im_we_a), .im_addr(im_addr_a), .im_wdata(im_wdata_a),
        .cpu_hold(cpu_hold_a), .done(done_a), .error(error_a), .words_loaded(words_loaded_a)
    );

    im_stream_loader #(.INSTR_W(15), .ADDR_W(4), .SYNC_BYTE(8'hA5)) dut_s (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .im_we(im_we_b), .im_addr(im_addr_b), .im_wdata(im_wdata_b),
        .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b), .words_loaded(words_loaded_b)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [14:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fw[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          pcyc = 0;
    int          last_drive_cyc = 0;
    int          writes_b = 0;
    bit          gaps = 0;
    bit          sel_a = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (im_we_a === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(im_addr_a), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("we_addr", 32'(im_addr_a), 32'(e.addr));
                check("we_data", 32'(im_wdata_a), 32'(e.data));
                check("we_latency", 32'(pcyc), 32'(e.cyc));
            end
        end
        if (im_we_b === 1'b1) writes_b <= writes_b + 1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid_a = 1'b0;
            in_valid_b = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (gaps) idle(1);
        @(negedge clk);
        in_data        = b;
        in_valid_a     = sel_a;
        in_valid_b     = !sel_a;
        last_drive_cyc = pcyc;
    endtask

    task automatic send_word(input int idx, input logic [15:0] w);
        exp_t e;
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        e.addr = 8'(idx);
        e.data = w[14:0];
        e.cyc  = last_drive_cyc + 1;
        if (sel_a) exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] chk_flip);
        logic [7:0] chk;
        chk = 8'(fw.size());
        send_byte(8'hA5);
        send_byte(8'(fw.size()));
        foreach (fw[i]) begin
            send_word(i, fw[i]);
            chk = chk ^ fw[i][7:0] ^ fw[i][15:8];
        end
        send_byte(chk ^ chk_flip);
        idle(2);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready_a), 32'd1);
        check({tag, "_im_we"}, 32'(im_we_a), 32'd0);
        check({tag, "_im_addr"}, 32'(im_addr_a), 32'd0);
        check({tag, "_im_wdata"}, 32'(im_wdata_a), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold_a), 32'd1);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_error"}, 32'(error_a), 32'd0);
        check({tag, "_words"}, 32'(words_loaded_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; in_data = 8'd0; in_valid_a = 1'b0; in_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        idle(2);

        // Good 4-word frame
        fw = '{16'h1234, 16'h0001, 16'h7FFF, 16'h0AAA};
        send_frame(8'h00);
        check("t1_done", 32'(done_a), 32'd1);
        check("t1_hold", 32'(cpu_hold_a), 32'd0);
        check("t1_error", 32'(error_a), 32'd0);
        check("t1_ready", 32'(in_ready_a), 32'd0);
        check("t1_words", 32'(words_loaded_a), 32'd4);
        pulse_start();
        check("t1_start_done", 32'(done_a), 32'd0);
        check("t1_start_hold", 32'(cpu_hold_a), 32'd1);
        check("t1_start_ready", 32'(in_ready_a), 32'd1);

        // Bad checksum: words still written, then error
        send_frame(8'h01);
        check("t2_error", 32'(error_a), 32'd1);
        check("t2_hold", 32'(cpu_hold_a), 32'd1);
        check("t2_done", 32'(done_a), 32'd0);
        check("t2_words", 32'(words_loaded_a), 32'd4);
        pulse_start();
        check("t2_start_error", 32'(error_a), 32'd0);
        check("t2_start_ready", 32'(in_ready_a), 32'd1);

        // Start in IDLE ignored; junk before sync; empty frame
        pulse_start();
        check("t3_idle_start", 32'(in_ready_a), 32'd1);
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        idle(2);
        check("t3_done", 32'(done_a), 32'd1);
        check("t3_words", 32'(words_loaded_a), 32'd0);
        pulse_start();

        // Gapped delivery, including a word with bit 15 set
        gaps = 1;
        fw = '{16'h0123, 16'hF00F, 16'h4ABC};
        send_frame(8'h00);
        gaps = 0;
        check("t4_done", 32'(done_a), 32'd1);
        check("t4_words", 32'(words_loaded_a), 32'd3);
        pulse_start();

        // Asynchronous reset mid-frame after two words
        fw = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        send_byte(8'hA5);
        send_byte(8'h04);
        send_word(0, fw[0]);
        send_word(1, fw[1]);
        idle(1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("t5_async");
        check("t5_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        fw = '{16'h0F0F, 16'h5A5A, 16'h00FF, 16'h7E01};
        send_frame(8'h00);
        check("t5_done", 32'(done_a), 32'd1);
        check("t5_words", 32'(words_loaded_a), 32'd4);

        // Oversized count on the ADDR_W=4 instance
        sel_a = 0;
        send_byte(8'hA5);
        send_byte(8'h11);
        idle(3);
        check("t6_error", 32'(error_b), 32'd1);
        check("t6_hold", 32'(cpu_hold_b), 32'd1);
        check("t6_ready", 32'(in_ready_b), 32'd0);
        check("t6_no_we", 32'(writes_b), 32'd0);

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
